mips_mc_controller: RTL and testbench

//  Multicycle MIPS control FSM; the issuing end of the ALU opsel interface. Walks each

---
 rtl/mips_mc_controller.sv | 244 ++++++++++++++++++++++++
 tb/tb_mips_mc_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WB and drives
// datapath enables, mux selects and the ALU operation select.

package alu_pkg;
    typedef enum logic [3:0] {
        C_ADD_U, C_SUB_U, C_AND, C_SRL, C_SRA, C_SLT, C_SLTU,
        C_MULT, C_MULTU, C_BLEZ, C_BGTZ
    } alu_sel_t;
endpackage

package mips_mc_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_FETCH_WAIT, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
        S_ADDR_CALC, S_MEM_RD, S_MEM_WAIT, S_WB_LOAD, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
    } state_t;
endpackage

module mips_mc_controller
    import alu_pkg::*;
    import mips_mc_pkg::*;
#(
    parameter int MEM_RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       branch_taken,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       jump_and_link,
    output logic       is_signed,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output alu_sel_t   opsel,
    output logic [1:0] alu_lo_hi,
    output logic       hi_en,
    output logic       lo_en,
    output logic       halted,
    output state_t     state_dbg
);

    localparam bit         NO_WAIT   = (MEM_RD_LAT == 0);
    localparam logic [2:0] LAST_WAIT = NO_WAIT ? 3'd0 : 3'(MEM_RD_LAT - 1);

    state_t     state, nxt;
    logic [2:0] cnt, cnt_nxt;
    logic [5:0] op_q, fn_q;
    logic       last_fetch;

    // The datapath gates the PC load with branch_taken itself; the FSM never needs it.
    logic unused_branch_taken;
    assign unused_branch_taken = branch_taken;

    function automatic logic is_exec_r_fn(input logic [5:0] fn);
        case (fn)
            6'h21, 6'h23, 6'h24, 6'h02, 6'h03, 6'h2A, 6'h2B,
            6'h18, 6'h19, 6'h08: is_exec_r_fn = 1'b1;
            default:             is_exec_r_fn = 1'b0;
        endcase
    endfunction

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        case (state)
            S_FETCH: begin
                if (NO_WAIT) begin
                    nxt = S_DECODE;
                end else begin
                    nxt     = S_FETCH_WAIT;
                    cnt_nxt = 3'd0;
                end
            end
            S_FETCH_WAIT: begin
                if (cnt == LAST_WAIT) nxt = S_DECODE;
                else                  cnt_nxt = cnt + 3'd1;
            end
            S_DECODE: begin
                case (opcode)
                    6'h00: begin
                        if (is_exec_r_fn(funct))                  nxt = S_EXEC_R;
                        else if (funct == 6'h10 || funct == 6'h12) nxt = S_WB_R;
                        else                                      nxt = S_HALT;
                    end
                    6'h09:        nxt = S_EXEC_I;
                    6'h23, 6'h2B: nxt = S_ADDR_CALC;
                    6'h06, 6'h07: nxt = S_BRANCH;
                    6'h02, 6'h03: nxt = S_JUMP;
                    default:      nxt = S_HALT;
                endcase
            end
            S_EXEC_R: begin
                // mult/multu land in HI/LO and jr only loads the PC: no regfile write-back.
                if (fn_q == 6'h18 || fn_q == 6'h19 || fn_q == 6'h08) nxt = S_FETCH;
                else                                                 nxt = S_WB_R;
            end
            S_EXEC_I:    nxt = S_WB_I;
            S_ADDR_CALC: nxt = (op_q == 6'h23) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (NO_WAIT) begin
                    nxt = S_WB_LOAD;
                end else begin
                    nxt     = S_MEM_WAIT;
                    cnt_nxt = 3'd0;
                end
            end
            S_MEM_WAIT: begin
                if (cnt == LAST_WAIT) nxt = S_WB_LOAD;
                else                  cnt_nxt = cnt + 3'd1;
            end
            S_WB_R, S_WB_I, S_WB_LOAD, S_MEM_WR, S_BRANCH, S_JUMP: nxt = S_FETCH;
            S_HALT:  nxt = S_HALT;
            default: nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            cnt   <= 3'd0;
            op_q  <= 6'd0;
            fn_q  <= 6'd0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            if (state == S_DECODE) begin
                op_q <= opcode;
                fn_q <= funct;
            end
        end
    end

    assign state_dbg  = state;
    assign last_fetch = (state == S_FETCH && NO_WAIT) ||
                        (state == S_FETCH_WAIT && cnt == LAST_WAIT);

    // Moore decode from registered state; rst forces every strobe low immediately.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        jump_and_link = 1'b0;
        is_signed     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        pc_source     = 2'd0;
        opsel         = C_ADD_U;
        alu_lo_hi     = 2'd0;
        hi_en         = 1'b0;
        lo_en         = 1'b0;
        halted        = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH, S_FETCH_WAIT: begin
                    mem_read = 1'b1;
                    if (last_fetch) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        alu_src_b = 2'd1;
                    end
                end
                S_DECODE: begin
                    alu_src_b = 2'd3;
                    is_signed = 1'b1;
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    case (fn_q)
                        6'h23:   opsel = C_SUB_U;
                        6'h24:   opsel = C_AND;
                        6'h02:   opsel = C_SRL;
                        6'h03:   opsel = C_SRA;
                        6'h2A:   opsel = C_SLT;
                        6'h2B:   opsel = C_SLTU;
                        6'h18:   opsel = C_MULT;
                        6'h19:   opsel = C_MULTU;
                        default: opsel = C_ADD_U;
                    endcase
                    if (fn_q == 6'h18 || fn_q == 6'h19) begin
                        hi_en = 1'b1;
                        lo_en = 1'b1;
                    end
                    if (fn_q == 6'h08) pc_write = 1'b1;
                end
                S_WB_R: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                    if (fn_q == 6'h10)      alu_lo_hi = 2'd2;
                    else if (fn_q == 6'h12) alu_lo_hi = 2'd1;
                end
                S_EXEC_I, S_ADDR_CALC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    is_signed = 1'b1;
                end
                S_WB_I: reg_write = 1'b1;
                S_MEM_RD, S_MEM_WAIT: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_WB_LOAD: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    opsel         = (op_q == 6'h06) ? C_BLEZ : C_BGTZ;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'd1;
                end
                S_JUMP: begin
                    pc_source = 2'd2;
                    pc_write  = 1'b1;
                    if (op_q == 6'h03) begin
                        reg_write     = 1'b1;
                        jump_and_link = 1'b1;
                    end
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: per-cycle vector table on an L=1 instance,
// plus halt, mid-store reset and L=2 load sequences.
module tb_mips_mc_controller;
    import alu_pkg::*;
    import mips_mc_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00, funct = 6'h21, opcode2 = 6'h23, funct2 = 6'h00;
    logic       bt = 1'b0;

    logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg;
    logic reg_dst, reg_write, jump_and_link, is_signed, alu_src_a, hi_en, lo_en, halted;
    logic [1:0] alu_src_b, pc_source, alu_lo_hi;
    alu_sel_t opsel;
    state_t   state;

    logic mem_read2, ir_write2, mem_to_reg2, reg_write2;
    logic unused2_pcw, unused2_pcwc, unused2_iord, unused2_mw, unused2_rd, unused2_jal;
    logic unused2_sgn, unused2_sa, unused2_hi, unused2_lo, unused2_halt;
    logic [1:0] unused2_sb, unused2_ps, unused2_lh;
    alu_sel_t unused2_opsel;
    state_t   state2;

    always #5 clk = ~clk;

    mips_mc_controller #(.MEM_RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .branch_taken(bt),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .jump_and_link(jump_and_link), .is_signed(is_signed), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_source(pc_source), .opsel(opsel), .alu_lo_hi(alu_lo_hi),
        .hi_en(hi_en), .lo_en(lo_en), .halted(halted), .state_dbg(state)
    );

    mips_mc_controller #(.MEM_RD_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .opcode(opcode2), .funct(funct2), .branch_taken(bt),
        .pc_write(unused2_pcw), .pc_write_cond(unused2_pcwc), .i_or_d(unused2_iord),
        .mem_read(mem_read2), .mem_write(unused2_mw), .ir_write(ir_write2),
        .mem_to_reg(mem_to_reg2), .reg_dst(unused2_rd), .reg_write(reg_write2),
        .jump_and_link(unused2_jal), .is_signed(unused2_sgn), .alu_src_a(unused2_sa),
        .alu_src_b(unused2_sb), .pc_source(unused2_ps), .opsel(unused2_opsel),
        .alu_lo_hi(unused2_lh), .hi_en(unused2_hi), .lo_en(unused2_lo),
        .halted(unused2_halt), .state_dbg(state2)
    );

    // strb = {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, hi_en, lo_en, halted}
    // ctl  = {jump_and_link, reg_dst, mem_to_reg, alu_lo_hi, pc_source, i_or_d, is_signed, alu_src_a, alu_src_b}
    logic [8:0]  strb;
    logic [11:0] ctl;
    assign strb = {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, hi_en, lo_en, halted};
    assign ctl  = {jump_and_link, reg_dst, mem_to_reg, alu_lo_hi, pc_source,
                   i_or_d, is_signed, alu_src_a, alu_src_b};

    localparam logic [8:0] ST_F0  = 9'b001000000;
    localparam logic [8:0] ST_FL  = 9'b101010000;
    localparam logic [8:0] ST_Z   = 9'b000000000;
    localparam logic [8:0] ST_WB  = 9'b000001000;
    localparam logic [8:0] ST_MW  = 9'b000100000;
    localparam logic [8:0] ST_MR  = 9'b001000000;
    localparam logic [8:0] ST_BR  = 9'b010000000;
    localparam logic [8:0] ST_J   = 9'b100000000;
    localparam logic [8:0] ST_JL  = 9'b100001000;
    localparam logic [8:0] ST_ML  = 9'b000000110;
    localparam logic [8:0] ST_HLT = 9'b000000001;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        bt;
        state_t      st;
        logic [8:0]  strb;
        logic [11:0] ctl;
        alu_sel_t    sel;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic add_vec(input logic [5:0] op, input logic [5:0] fn, input logic b,
                           input state_t st, input logic [8:0] s, input logic [11:0] c,
                           input alu_sel_t sel);
        vec_t v;
        v.op = op; v.fn = fn; v.bt = b; v.st = st; v.strb = s; v.ctl = c; v.sel = sel;
        vecs.push_back(v);
    endtask

    // Fetch (L=1) and decode rows common to every instruction.
    task automatic add_fetch(input logic [5:0] op, input logic [5:0] fn, input logic b);
        add_vec(op, fn, b, S_FETCH,      ST_F0, 12'b0000000_00000, C_ADD_U);
        add_vec(op, fn, b, S_FETCH_WAIT, ST_FL, 12'b0000000_00001, C_ADD_U);
        add_vec(op, fn, b, S_DECODE,     ST_Z,  12'b0000000_01011, C_ADD_U);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        opcode = v.op;
        funct  = v.fn;
        bt     = v.bt;
        #1;
        check($sformatf("row%0d_state", idx), 32'(state), 32'(v.st));
        check($sformatf("row%0d_strb",  idx), 32'(strb),  32'(v.strb));
        check($sformatf("row%0d_ctl",   idx), 32'(ctl),   32'(v.ctl));
        check($sformatf("row%0d_opsel", idx), 32'(opsel), 32'(v.sel));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic hold_halt(input string tag);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("%s_halt_state%0d", tag, i), 32'(state), 32'(S_HALT));
            check($sformatf("%s_halt_strb%0d",  tag, i), 32'(strb),  32'(ST_HLT));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        state_t   lw_st[9];
        logic     lw_mr[9];
        vec_t     v;
        int       base;

        // addu, subu, sltu
        add_fetch(6'h00, 6'h21, 1'b0);
        add_vec(6'h00, 6'h21, 1'b0, S_EXEC_R, ST_Z,  12'b0000000_00100, C_ADD_U);
        add_vec(6'h00, 6'h21, 1'b0, S_WB_R,   ST_WB, 12'b0100000_00000, C_ADD_U);
        add_fetch(6'h00, 6'h23, 1'b0);
        add_vec(6'h00, 6'h23, 1'b0, S_EXEC_R, ST_Z,  12'b0000000_00100, C_SUB_U);
        add_vec(6'h00, 6'h23, 1'b0, S_WB_R,   ST_WB, 12'b0100000_00000, C_ADD_U);
        add_fetch(6'h00, 6'h2B, 1'b0);
        add_vec(6'h00, 6'h2B, 1'b0, S_EXEC_R, ST_Z,  12'b0000000_00100, C_SLTU);
        add_vec(6'h00, 6'h2B, 1'b0, S_WB_R,   ST_WB, 12'b0100000_00000, C_ADD_U);
        // addiu
        add_fetch(6'h09, 6'h00, 1'b0);
        add_vec(6'h09, 6'h00, 1'b0, S_EXEC_I, ST_Z,  12'b0000000_01110, C_ADD_U);
        add_vec(6'h09, 6'h00, 1'b0, S_WB_I,   ST_WB, 12'b0000000_00000, C_ADD_U);
        // sw, lw (L=1: 5 and 7 cycles)
        add_fetch(6'h2B, 6'h00, 1'b0);
        add_vec(6'h2B, 6'h00, 1'b0, S_ADDR_CALC, ST_Z,  12'b0000000_01110, C_ADD_U);
        add_vec(6'h2B, 6'h00, 1'b0, S_MEM_WR,    ST_MW, 12'b0000000_10000, C_ADD_U);
        add_fetch(6'h23, 6'h00, 1'b0);
        add_vec(6'h23, 6'h00, 1'b0, S_ADDR_CALC, ST_Z,  12'b0000000_01110, C_ADD_U);
        add_vec(6'h23, 6'h00, 1'b0, S_MEM_RD,    ST_MR, 12'b0000000_10000, C_ADD_U);
        add_vec(6'h23, 6'h00, 1'b0, S_MEM_WAIT,  ST_MR, 12'b0000000_10000, C_ADD_U);
        add_vec(6'h23, 6'h00, 1'b0, S_WB_LOAD,   ST_WB, 12'b0010000_00000, C_ADD_U);
        // bgtz taken / not taken, blez
        add_fetch(6'h07, 6'h00, 1'b1);
        add_vec(6'h07, 6'h00, 1'b1, S_BRANCH, ST_BR, 12'b0000001_00100, C_BGTZ);
        add_fetch(6'h07, 6'h00, 1'b0);
        add_vec(6'h07, 6'h00, 1'b0, S_BRANCH, ST_BR, 12'b0000001_00100, C_BGTZ);
        add_fetch(6'h06, 6'h00, 1'b0);
        add_vec(6'h06, 6'h00, 1'b0, S_BRANCH, ST_BR, 12'b0000001_00100, C_BLEZ);
        // mult then mfhi, mflo
        add_fetch(6'h00, 6'h18, 1'b0);
        add_vec(6'h00, 6'h18, 1'b0, S_EXEC_R, ST_ML, 12'b0000000_00100, C_MULT);
        add_fetch(6'h00, 6'h10, 1'b0);
        add_vec(6'h00, 6'h10, 1'b0, S_WB_R,   ST_WB, 12'b0101000_00000, C_ADD_U);
        add_fetch(6'h00, 6'h12, 1'b0);
        add_vec(6'h00, 6'h12, 1'b0, S_WB_R,   ST_WB, 12'b0100100_00000, C_ADD_U);
        // jr, jal
        add_fetch(6'h00, 6'h08, 1'b0);
        add_vec(6'h00, 6'h08, 1'b0, S_EXEC_R, ST_J,  12'b0000000_00100, C_ADD_U);
        add_fetch(6'h03, 6'h00, 1'b0);
        add_vec(6'h03, 6'h00, 1'b0, S_JUMP,   ST_JL, 12'b1000010_00000, C_ADD_U);
        // back-to-back FETCH after jal, then halt opcode
        add_fetch(6'h3F, 6'h00, 1'b0);
        add_vec(6'h3F, 6'h00, 1'b0, S_HALT,   ST_HLT, 12'b0000000_00000, C_ADD_U);

        // Reset state
        @(negedge clk);
        #1;
        check("rst_state", 32'(state), 32'(S_FETCH));
        check("rst_strb",  32'(strb),  32'(ST_Z));
        check("rst_ctl",   32'(ctl),   32'(12'd0));
        check("rst_opsel", 32'(opsel), 32'(C_ADD_U));
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);
        hold_halt("op3f");

        // Unsupported R-type funct
        pulse_reset();
        base = vecs.size();
        add_fetch(6'h00, 6'h3E, 1'b0);
        add_vec(6'h00, 6'h3E, 1'b0, S_HALT, ST_HLT, 12'b0000000_00000, C_ADD_U);
        for (int i = base; i < vecs.size(); i++) run_vec(vecs[i], i);
        hold_halt("fn3e");

        // Reset asserted during MEM_WR
        pulse_reset();
        base = vecs.size();
        add_fetch(6'h2B, 6'h00, 1'b0);
        add_vec(6'h2B, 6'h00, 1'b0, S_ADDR_CALC, ST_Z,  12'b0000000_01110, C_ADD_U);
        add_vec(6'h2B, 6'h00, 1'b0, S_MEM_WR,    ST_MW, 12'b0000000_10000, C_ADD_U);
        for (int i = base; i < vecs.size(); i++) run_vec(vecs[i], i);
        #1 rst = 1'b1;
        #1;
        check("midwr_mem_write", 32'(mem_write), 32'd0);
        check("midwr_state",     32'(state),     32'(S_FETCH));
        check("midwr_strb",      32'(strb),      32'(ST_Z));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_state",    32'(state),    32'(S_FETCH));
        check("post_rst_mem_read", 32'(mem_read), 32'd1);

        // lw on the L=2 instance: 9 cycles, two mem_read windows
        lw_st = '{S_FETCH, S_FETCH_WAIT, S_FETCH_WAIT, S_DECODE, S_ADDR_CALC,
                  S_MEM_RD, S_MEM_WAIT, S_MEM_WAIT, S_WB_LOAD};
        lw_mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        pulse_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("lw2_state%0d", i), 32'(state2),    32'(lw_st[i]));
            check($sformatf("lw2_mr%0d", i),    32'(mem_read2), 32'(lw_mr[i]));
            check($sformatf("lw2_irw%0d", i),   32'(ir_write2), 32'(i == 2));
            check($sformatf("lw2_m2r%0d", i),   32'(mem_to_reg2), 32'(i == 8));
            check($sformatf("lw2_rw%0d", i),    32'(reg_write2),  32'(i == 8));
        end
        @(negedge clk);
        #1;
        check("lw2_next_fetch", 32'(state2), 32'(S_FETCH));

        v = vecs[0];
        if (v.st != S_FETCH) $display("table construction error");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
